// File: rtl/mat_loader.sv
// Byte-stream loader: packs four bytes per word little-endian and writes matrix A then B,
// then optionally kicks matmul_top once it reports ready.
module mat_loader #(
  parameter int unsigned       ADDR_W        = 10,
  parameter logic [ADDR_W-1:0] BASE_A        = 'h000,
  parameter logic [ADDR_W-1:0] BASE_B        = 'h100,
  parameter int unsigned       WORDS_PER_MAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              auto_kick_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              mem_en_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic              matmul_ready_i,
  output logic              kick_start_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned WcW = $clog2(WORDS_PER_MAT);

  typedef enum logic [2:0] {
    StIdle, StLoadA, StLoadB, StWaitRdy, StKick, StDone
  } state_e;

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [WcW-1:0]    word_cnt_q;
  logic [23:0]       pack_q;
  logic              auto_kick_q;
  logic              in_ready_q, mem_en_write_q, kick_q, busy_q, done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_data_q;

  logic accept, byte_last, word_last;

  assign accept    = in_valid_i & in_ready_q;
  assign byte_last = (byte_cnt_q == 2'd3);
  assign word_last = (word_cnt_q == WcW'(WORDS_PER_MAT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      byte_cnt_q     <= '0;
      word_cnt_q     <= '0;
      pack_q         <= '0;
      auto_kick_q    <= 1'b0;
      in_ready_q     <= 1'b0;
      mem_en_write_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      kick_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      mem_en_write_q <= 1'b0;
      kick_q         <= 1'b0;
      done_q         <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        // A partial word is simply forgotten; a write issued last cycle has already gone out.
        state_q    <= StIdle;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
        byte_cnt_q <= '0;
        word_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q     <= StLoadA;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
              byte_cnt_q  <= '0;
              word_cnt_q  <= '0;
              auto_kick_q <= auto_kick_i;
            end
          end
          StLoadA, StLoadB: begin
            if (accept) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              pack_q     <= {in_data_i, pack_q[23:8]};
              if (byte_last) begin
                mem_en_write_q <= 1'b1;
                mem_addr_q     <= ((state_q == StLoadA) ? BASE_A : BASE_B) + ADDR_W'(word_cnt_q);
                mem_data_q     <= {in_data_i, pack_q};
                word_cnt_q     <= word_cnt_q + 1'b1;
                if (word_last) begin
                  if (state_q == StLoadA) begin
                    state_q <= StLoadB;
                  end else begin
                    in_ready_q <= 1'b0;
                    state_q    <= auto_kick_q ? StWaitRdy : StDone;
                  end
                end
              end
            end
          end
          StWaitRdy: begin
            if (matmul_ready_i) begin
              state_q <= StKick;
              kick_q  <= 1'b1;
            end
          end
          StKick: begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
          StDone: begin
            // Entered without a kick, done is raised one cycle later so it trails the last write.
            if (done_q) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign in_ready_o     = in_ready_q;
  assign mem_en_write_o = mem_en_write_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;
  assign kick_start_o   = kick_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_mat_loader.sv
// Directed bench for mat_loader: write order/content, kick and done timing, abort, reset.
module tb_mat_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, auto_kick = 1'b0;
  logic        in_valid = 1'b0, matmul_ready = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_en_write, kick_start, busy, done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;

  int          cyc = 0;
  logic [9:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          kick_cnt = 0, kick_cyc = -1, done_cnt = 0, done_cyc = -1;
  int          n_cmp = 0, n_fail = 0;
  int          last_hs = 0, start_cyc = 0;

  logic [7:0]  stim  [32];
  logic [9:0]  exp_a [8];
  logic [31:0] exp_d [8];

  mat_loader dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .abort_i        (abort),
    .auto_kick_i    (auto_kick),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_ready_o     (in_ready),
    .mem_en_write_o (mem_en_write),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_data),
    .matmul_ready_i (matmul_ready),
    .kick_start_o   (kick_start),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_en_write) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      wc.push_back(cyc);
    end
    if (kick_start) begin
      kick_cnt++;
      kick_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
    kick_cnt = 0; kick_cyc = -1; done_cnt = 0; done_cyc = -1;
  endtask

  // Called and returns at a negedge.
  task automatic do_start(input logic ak);
    start = 1'b1; auto_kick = ak; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; auto_kick = 1'b0;
  endtask

  // Streams stim[lo..hi-1]; called and returns at a negedge with in_valid low.
  task automatic drive_bytes(input int lo, input int hi, input bit gaps);
    int idx = lo;
    int guard = 0;
    bit hs;
    while (idx < hi) begin
      in_valid = gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
      in_data  = stim[idx];
      hs = in_valid && in_ready;
      if (hs) last_hs = cyc;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        n_cmp++; n_fail++;
        $display("FAIL stream_timeout: accepted %0d bytes, required %0d", idx - lo, hi - lo);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({in_ready, mem_en_write, kick_start, busy, done} !== 5'b0 || mem_addr !== 10'h0 ||
        mem_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/we/kick/busy/done=%b addr=%h data=%h, required 0",
               {in_ready, mem_en_write, kick_start, busy, done}, mem_addr, mem_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_plain_load();
    int lw;
    clear_log();
    do_start(1'b0);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: busy=%b in_ready=%b, required 1 1", busy, in_ready);
    end
    drive_bytes(0, 32, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_drop_after_last: in_ready=%b, required 0", in_ready);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (wa.size() != 8) begin
      n_fail++;
      $display("FAIL plain_write_count: got %0d, required 8", wa.size());
    end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      n_cmp++;
      if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL plain_write%0d: got %h=%h, required %h=%h", i, wa[i], wd[i], exp_a[i],
                 exp_d[i]);
      end
    end
    lw = (wc.size() > 0) ? wc[wc.size()-1] : -100;
    n_cmp++;
    if (lw - start_cyc != 33 || lw != last_hs + 1) begin
      n_fail++;
      $display("FAIL last_write_cycle: got %0d (hs %0d), required %0d", lw - start_cyc,
               last_hs - start_cyc, 33);
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != lw + 1 || kick_cnt != 0) begin
      n_fail++;
      $display("FAIL plain_done: done_cnt=%0d at %0d kicks=%0d, required 1 at %0d kicks=0",
               done_cnt, done_cyc, kick_cnt, lw + 1);
    end
  endtask

  task automatic test_gappy_load();
    clear_log();
    do_start(1'b0);
    drive_bytes(0, 32, 1'b1);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (wa.size() != 8 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL gappy_counts: writes=%0d done=%0d, required 8 1", wa.size(), done_cnt);
    end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      n_cmp++;
      if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL gappy_write%0d: got %h=%h, required %h=%h", i, wa[i], wd[i], exp_a[i],
                 exp_d[i]);
      end
    end
  endtask

  task automatic test_auto_kick();
    int r;
    clear_log();
    do_start(1'b1);
    drive_bytes(0, 32, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (kick_cnt != 0 || done_cnt != 0 || busy !== 1'b1 || wa.size() != 8) begin
      n_fail++;
      $display("FAIL kick_wait: kicks=%0d done=%0d busy=%b writes=%0d, required 0 0 1 8",
               kick_cnt, done_cnt, busy, wa.size());
    end
    matmul_ready = 1'b1; r = cyc;
    repeat (3) @(negedge clk);
    matmul_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (kick_cnt != 1 || kick_cyc != r + 1) begin
      n_fail++;
      $display("FAIL kick_pulse: %0d pulses at %0d, required 1 at %0d", kick_cnt, kick_cyc,
               r + 1);
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != r + 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL kick_done: %0d at %0d busy=%b, required 1 at %0d busy=0", done_cnt,
               done_cyc, busy, r + 2);
    end
  endtask

  task automatic test_abort();
    clear_log();
    do_start(1'b0);
    drive_bytes(0, 6, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wa.size() != 1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_writes: writes=%0d done=%0d, required 1 0", wa.size(), done_cnt);
    end else if (wa[0] !== 10'h000 || wd[0] !== 32'h08070605) begin
      n_fail++;
      $display("FAIL abort_word0: got %h=%h, required 000=08070605", wa[0], wd[0]);
    end
    clear_log();
    do_start(1'b0);
    drive_bytes(0, 32, 1'b0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wa.size() != 8 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL reload_counts: writes=%0d done=%0d, required 8 1", wa.size(), done_cnt);
    end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      n_cmp++;
      if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL reload_write%0d: got %h=%h, required %h=%h", i, wa[i], wd[i], exp_a[i],
                 exp_d[i]);
      end
    end
  endtask

  task automatic test_start_in_load_b();
    clear_log();
    do_start(1'b0);
    drive_bytes(0, 22, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_bytes(22, 32, 1'b0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wa.size() != 8 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL midstart_counts: writes=%0d done=%0d, required 8 1", wa.size(), done_cnt);
    end
    for (int i = 4; i < 8 && i < wa.size(); i++) begin
      n_cmp++;
      if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL midstart_write%0d: got %h=%h, required %h=%h", i, wa[i], wd[i], exp_a[i],
                 exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    do_start(1'b0);
    drive_bytes(0, 10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, mem_en_write, kick_start, busy, done} !== 5'b0 || mem_addr !== 10'h0 ||
        mem_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: rdy/we/kick/busy/done=%b addr=%h data=%h, required 0",
               {in_ready, mem_en_write, kick_start, busy, done}, mem_addr, mem_data);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || wa.size() != 2) begin
      n_fail++;
      $display("FAIL post_reset: in_ready=%b busy=%b writes=%0d, required 0 0 2", in_ready,
               busy, wa.size());
    end
  endtask

  initial begin
    logic [7:0]  a_b [16];
    logic [7:0]  b_b [16];
    logic [31:0] ed  [8];
    a_b = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4,
            8'd13, 8'd14, 8'd15, 8'd16, 8'd9, 8'd10, 8'd11, 8'd12};
    b_b = '{8'd3, 8'd4, 8'd1, 8'd2, 8'd7, 8'd8, 8'd5, 8'd6,
            8'd11, 8'd12, 8'd9, 8'd10, 8'd15, 8'd16, 8'd13, 8'd14};
    ed  = '{32'h08070605, 32'h04030201, 32'h100F0E0D, 32'h0C0B0A09,
            32'h02010403, 32'h06050807, 32'h0A090C0B, 32'h0E0D100F};
    for (int i = 0; i < 16; i++) begin
      stim[i]      = a_b[i];
      stim[16 + i] = b_b[i];
    end
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = ed[i];
      exp_a[i] = (i < 4) ? 10'(i) : 10'(32'h100 + i - 4);
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_plain_load();
    test_gappy_load();
    test_auto_kick();
    test_abort();
    test_start_in_load_b();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_loader.md
# mat_loader

Stream-to-memory loader that fills the operand regions read by `matmul_top`. It accepts a byte stream over a valid/ready handshake and packs four bytes per 32-bit word. It writes matrix A at `BASE_A` and then matrix B at `BASE_B` through the same single-word write port style as `mem_top`'s port C. It then optionally issues `kick_start` to `matmul_top` once that block reports `ready`.

## Interface
- `ADDR_W`, 10, memory word address width
- `BASE_A`, 10'h000, first word address of matrix A
- `BASE_B`, 10'h100, first word address of matrix B
- `WORDS_PER_MAT`, 4, words per matrix (power of two, ≥2)

- `clk`  in  1  single clock, all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a load; sampled only in IDLE
- `abort`  in  1  synchronous cancel; return to IDLE, discard partial word
- `auto_kick`  in  1  sampled at `start`; when 1, issue `kick_start` after load
- `in_valid`  in  1  byte valid
- `in_data`  in  8  byte payload
- `in_ready`  out  1  loader accepts byte this cycle
- `mem_en_write`  out  1  one-cycle write strobe
- `mem_addr`  out  ADDR_W  write address
- `mem_data`  out  32  write data
- `matmul_ready`  in  1  `ready` from `matmul_top`
- `kick_start`  out  1  one-cycle start pulse to `matmul_top`
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD_A, LOAD_B, WAIT_RDY, KICK, DONE.
- IDLE→LOAD_A on `start`. `byte_cnt` and `word_cnt` are cleared, and `auto_kick` is latched.
- A byte is accepted when `in_valid & in_ready`. `in_ready` = 1 in LOAD_A and LOAD_B only, and is a registered, state-derived output.
- Packing: the k-th accepted byte of a word (k=0..3) lands in bits [8k+7:8k]. Stream bytes 5,6,7,8 produce word 32'h08070605.
- On the 4th byte of a word, the write is registered for the next cycle: `mem_en_write`=1, `mem_addr`=base+`word_cnt`, `mem_data`=packed word. `word_cnt` then increments.
- LOAD_A→LOAD_B on the byte that completes word `WORDS_PER_MAT`-1. `word_cnt` wraps to 0 and `byte_cnt` continues without a gap.
- LOAD_B→WAIT_RDY (latched `auto_kick`=1) or →DONE (0) on the byte that completes the final B word.
- WAIT_RDY→KICK when `matmul_ready`=1. KICK asserts `kick_start` for exactly one cycle, then →DONE.
- DONE asserts `done` for one cycle, then →IDLE.
- `abort` (any non-IDLE state) →IDLE next cycle; highest priority over all other transitions.
  - Bytes of a partially packed word are dropped; no write occurs for them.
  - A write already registered from the previous cycle still completes.
  - No `done` or `kick_start` is issued.
- `start` while `busy` is ignored. `in_valid` outside LOAD_A/LOAD_B is ignored.
- `mem_addr` and `mem_data` hold their last values when `mem_en_write`=0.

## Timing
- Reset values: `in_ready`, `mem_en_write`, `kick_start`, `busy`, `done` = 0; `mem_addr`, `mem_data` = 0; state = IDLE; counters = 0.
- `start` at cycle 0 → `busy`=1 and `in_ready`=1 from cycle 1.
- Write latency is 1 cycle after the 4th-byte handshake.
- Best-case load with `in_valid` held high is 8·`WORDS_PER_MAT` accept cycles. For defaults: 32 cycles, last write at cycle 33.
- After the final B byte, `in_ready`=0 from the next cycle.
- `kick_start` is never asserted before the cycle following the final B write.
  - Earliest `kick_start` is 2 cycles after the final byte handshake.
  - `done` is 1 cycle after `kick_start`, or 1 cycle after the final write when there is no kick.
- A last-A-word write may coincide with the first B byte accept; this is legal.
- Reset asserted mid-load: all outputs reach reset values immediately (asynchronous). Memory contents already written remain.

## Test plan
- Plain load, `auto_kick`=0:
  - Stream bytes 5,6,7,8,1,2,3,4,13..16,9..12 (A), then 3,4,1,2,7,8,5,6,11,12,9,10,15,16,13,14 (B).
  - Expect writes 0x000=08070605, 0x001=04030201, 0x002=100F0E0D, 0x003=0C0B0A09, 0x100=02010403, 0x101=06050807, 0x102=0A090C0B, 0x103=0E0D100F.
  - Expect exactly 8 writes, `done` one cycle after the 0x103 write, and no `kick_start`.
- Same data with `in_valid` randomly deasserted ~50% of cycles → identical 8 writes, in order.
- `auto_kick`=1, `matmul_ready`=0 for 10 cycles after the final write:
  - No `kick_start` while `matmul_ready`=0.
  - A single `kick_start` pulse the cycle after `matmul_ready` rises.
  - `done` the next cycle.
  - Full loop with `matmul_top` + `mem_top` → result at 0x200 nonzero.
- `abort` after 6 bytes of A → only the 0x000 write occurs (none at 0x001); `busy`=0 next cycle; no `done`. A subsequent full load writes all 8 words correctly.
- `start` pulsed mid-LOAD_B → ignored, and write addresses continue unchanged.
- `rstn` low after 10 bytes → all outputs 0 asynchronously; after release, `in_ready`=0 until `start`.
